rotate_sequencer: RTL and testbench
===================================

# rotate_sequencer

Command-driven controller for the mux/register/rotate datapath. It accepts one command at a time: select operand `a` or `b`, load it into the working register, rotate it by N single-bit steps in the chosen direction, and signal completion. It owns the datapath's `sel`, `r_l`, load and rotate controls and holds the result register. Upstream logic uses it instead of driving `sel` and `r_l` by hand.

## Interface
- `DATA_WIDTH`, 8: operand and result width.
- `CNT_WIDTH`, 4: width of the rotate-step count.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `a`  in  DATA_WIDTH  operand 0.
- `b`  in  DATA_WIDTH  operand 1.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_src`  in  1  operand select: 0=`a`, 1=`b`.
- `cmd_dir`  in  1  rotate direction: 1=left (toward MSB), 0=right.
- `cmd_count`  in  CNT_WIDTH  number of 1-bit rotate steps.
- `abort`  in  1  cancel the operation in progress.
- `sel`  out  1  mux select to the datapath.
- `r_l`  out  1  rotate direction to the datapath.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `q`  out  DATA_WIDTH  working/result register.

## Operation
- FSM states: IDLE, LOAD, ROTATE, DONE. `busy` = (state != IDLE). `cmd_ready` = (state == IDLE).
- IDLE:
  - `sel`=0, `r_l`=0.
  - On `cmd_valid && cmd_ready`, latch `cmd_src`, `cmd_dir` and `cmd_count` into internal registers, then go to LOAD.
- LOAD:
  - `sel` = latched src; `q` <= latched src ? `b` : `a`.
  - `a`/`b` are sampled at the LOAD edge, not at the handshake edge.
  - Remaining-step counter <= latched count.
  - Next state: DONE if count==0, else ROTATE.
- ROTATE:
  - Each edge: rotate `q` by one bit in the latched direction and decrement the remaining counter.
  - When the counter goes 1→0, next state is DONE.
  - Left rotate: `q` <= {q[W-2:0], q[W-1]}. Right rotate: `q` <= {q[0], q[W-1:1]}.
- DONE: `done`=1 for exactly this cycle, `q` holds, next state IDLE. No command is accepted in DONE.
- While busy, `sel` and `r_l` reflect the latched command. Command inputs are ignored while busy.
- Counts of DATA_WIDTH or more are executed literally, one step per cycle. There is no modulo shortcut; the result equals rotation by count mod DATA_WIDTH.
- `abort`:
  - Sampled high in LOAD or ROTATE, the next state is IDLE.
  - No `done` pulse is issued and `q` is not updated on that edge, so it holds its partial value.
  - `abort` takes priority over load and rotate on the same edge. It is ignored in IDLE and DONE.
- `rst` high at any edge, including mid-operation:
  - state=IDLE, `q`=0, all latched command fields and counter=0.
  - `rst` takes priority over `abort` and the handshake.
- `q` holds its value between operations until the next LOAD edge.

## Timing
- Reset values: `q`=0, `done`=0, `busy`=0, `cmd_ready`=1, `sel`=0, `r_l`=0.
- Let E0 be the handshake edge. LOAD is active in the cycle after E0, and E1 loads `q`. Rotate edges are E2 … E(1+count).
- `done` is high in the cycle following E(1+count). Latency from handshake edge to `done` is count+2 cycles (count=0 gives 2).
- `cmd_ready` rises in the cycle after the `done` cycle. The minimum command spacing is count+3 cycles.
- The final `q` is valid in the `done` cycle and stays stable until the next LOAD edge.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst` for 2 cycles → `q`=0x00, `cmd_ready`=1, `busy`=0, `done`=0, `sel`=0, `r_l`=0. Assert `rst` during ROTATE → IDLE with `q`=0 at the next edge and no `done`.
- `a`=0x81, src=0, dir=left, count=1 → `q`=0x03, `done` one cycle, 3 cycles after E0, `sel`=0 while busy.
- `b`=0x01, src=1, dir=right, count=3 → `q`=0x20, `done` 5 cycles after E0, `sel`=1 and `r_l`=0 while busy. `cmd_valid` held high during busy is not accepted.
- count=0, `a`=0xA5 → `q`=0xA5, `done` 2 cycles after E0. Then count=9, left, on `a`=0x01 → `q`=0x02 after 9 rotate edges.
- Abort: `a`=0x01, left, count=5; assert `abort` at E4 → `q`=0x04, no `done`, `cmd_ready`=1 in the following cycle. A new command is then accepted normally.
- Back-to-back: keep `cmd_valid` high with two queued commands → the second handshake occurs exactly 1 cycle after the first `done` cycle.

Source files
------------

// File: rtl/rotate_sequencer.sv
// Command sequencer for the mux/register/rotate datapath: select an operand, load it,
// rotate it one bit per cycle in the chosen direction, then pulse done.
module rotate_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_src,
  input  logic                  cmd_dir,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic                  abort,
  output logic                  sel,
  output logic                  r_l,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] q
);

  typedef enum logic [1:0] {StIdle, StLoad, StRotate, StDone} state_e;

  state_e                state_q, state_d;
  logic                  src_q, src_d;
  logic                  dir_q, dir_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] q_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dir_d   = dir_q;
    count_d = count_q;
    rem_d   = rem_q;
    q_d     = q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          src_d   = cmd_src;
          dir_d   = cmd_dir;
          count_d = cmd_count;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // abort leaves q untouched so the partial value stays visible
        if (abort) begin
          state_d = StIdle;
        end else begin
          q_d     = src_q ? b : a;
          rem_d   = count_q;
          state_d = (count_q == '0) ? StDone : StRotate;
        end
      end
      StRotate: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          q_d   = dir_q ? {q[DATA_WIDTH-2:0], q[DATA_WIDTH-1]} : {q[0], q[DATA_WIDTH-1:1]};
          rem_d = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= 1'b0;
      dir_q   <= 1'b0;
      count_q <= '0;
      rem_q   <= '0;
      q       <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      q       <= q_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign cmd_ready = (state_q == StIdle);
  assign done      = (state_q == StDone);
  assign sel       = busy & src_q;
  assign r_l       = busy & dir_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Bench for rotate_sequencer: a phase-indexed reference model checked every cycle,
// plus directed commands with hand-computed results and latencies.
module tb_rotate_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cmd_valid, cmd_ready, cmd_src, cmd_dir, abort;
  logic [3:0] cmd_count;
  logic       sel, r_l, busy, done;
  logic [7:0] q;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  rotate_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dir(cmd_dir),
    .cmd_count(cmd_count), .abort(abort),
    .sel(sel), .r_l(r_l), .busy(busy), .done(done), .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] x, input int n, input logic left);
    logic [15:0] t;
    t = {x, x};
    if (left) begin
      t = t << (n % 8);
      return t[15:8];
    end
    t = t >> (n % 8);
    return t[7:0];
  endfunction

  // Model: p is the cycle index since the handshake edge (0 = idle, 1 = load cycle,
  // count+2 = done cycle); q is the loaded operand rotated by (p-1) steps.
  int         p = 0;
  int         m_cnt = 0;
  logic       m_src = 1'b0, m_dir = 1'b0;
  logic [7:0] m_op = 8'h00, mq = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      p  = 0;
      mq = 8'h00;
    end else if (p == 0) begin
      if (cmd_valid) begin
        p = 1; m_src = cmd_src; m_dir = cmd_dir; m_cnt = int'(cmd_count);
      end
    end else if (abort && p <= m_cnt + 1) begin
      p = 0;
    end else begin
      if (p == 1) begin
        m_op = m_src ? b : a;
        mq   = m_op;
      end else if (p <= m_cnt + 1) begin
        mq = rot(m_op, p - 1, m_dir);
      end
      if (p == m_cnt + 2) p = 0;
      else p++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", {24'h0, q}, {24'h0, mq});
      chk("busy", {31'h0, busy}, {31'h0, p != 0});
      chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, p == 0});
      chk("done", {31'h0, done}, {31'h0, p != 0 && p == m_cnt + 2});
      chk("sel", {31'h0, sel}, {31'h0, p != 0 && m_src});
      chk("r_l", {31'h0, r_l}, {31'h0, p != 0 && m_dir});
    end
  end

  // Call away from a rising edge; returns 2 time units after the handshake edge.
  task automatic issue(input logic s, input logic d, input logic [3:0] c, input logic keep);
    bit hs = 1'b0;
    cmd_src = s; cmd_dir = d; cmd_count = c; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !hs; i++) begin
      hs = cmd_ready;
      @(posedge clk);
      if (!hs) @(negedge clk);
    end
    if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
    #2;
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Counts cycles (falling edges) until done is seen; n=0 on timeout.
  task automatic wait_done(output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) begin
      chk("done_timeout", 32'd0, 32'd1);
      n = 0;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; a = 8'h00; b = 8'h00; cmd_valid = 1'b0; cmd_src = 1'b0;
    cmd_dir = 1'b0; cmd_count = 4'd0; abort = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_q", {24'h0, q}, 32'h00);
    chk("rst_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_sel", {31'h0, sel}, 32'd0);
    chk("rst_rl", {31'h0, r_l}, 32'd0);
    rst = 1'b0;

    // operand changes after the handshake; the LOAD-edge value must be used
    a = 8'hFF;
    issue(1'b0, 1'b1, 4'd1, 1'b0);
    a = 8'h81;
    wait_done(n);
    chk("t1_lat", n, 32'd3);
    chk("t1_q", {24'h0, q}, 32'h03);

    // cmd_valid held high while busy must not start a second command
    b = 8'h01;
    issue(1'b1, 1'b0, 4'd3, 1'b1);
    wait_done(n);
    cmd_valid = 1'b0;
    chk("t2_lat", n, 32'd5);
    chk("t2_q", {24'h0, q}, 32'h20);

    a = 8'hA5;
    issue(1'b0, 1'b1, 4'd0, 1'b0);
    wait_done(n);
    chk("t3_lat", n, 32'd2);
    chk("t3_q", {24'h0, q}, 32'hA5);

    a = 8'h01;
    issue(1'b0, 1'b1, 4'd9, 1'b0);
    wait_done(n);
    chk("t4_lat", n, 32'd11);
    chk("t4_q", {24'h0, q}, 32'h02);

    // reset while rotating
    a = 8'h5A;
    issue(1'b0, 1'b1, 4'd5, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_q", {24'h0, q}, 32'h00);
    chk("rst_mid_busy", {31'h0, busy}, 32'd0);
    chk("rst_mid_done", {31'h0, done}, 32'd0);
    rst = 1'b0;

    // abort sampled at E4 leaves the partial rotation in q
    a = 8'h01;
    issue(1'b0, 1'b1, 4'd5, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    @(negedge clk);
    chk("abort_q", {24'h0, q}, 32'h04);
    chk("abort_ready", {31'h0, cmd_ready}, 32'd1);
    chk("abort_done", {31'h0, done}, 32'd0);
    b = 8'h80;
    issue(1'b1, 1'b1, 4'd2, 1'b0);
    wait_done(n);
    chk("post_abort_lat", n, 32'd4);
    chk("post_abort_q", {24'h0, q}, 32'h02);

    // back-to-back: second handshake one cycle after the first done cycle
    a = 8'h0F;
    issue(1'b0, 1'b0, 4'd2, 1'b1);
    wait_done(n);
    chk("b2b1_lat", n, 32'd4);
    chk("b2b1_q", {24'h0, q}, 32'hC3);
    cmd_src = 1'b1; cmd_dir = 1'b1; cmd_count = 4'd1; b = 8'h40;
    @(negedge clk);
    chk("b2b_ready_gap", {31'h0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("b2b_second_busy", {31'h0, busy}, 32'd1);
    cmd_valid = 1'b0;
    wait_done(n);
    chk("b2b2_lat", n, 32'd2);
    chk("b2b2_q", {24'h0, q}, 32'h80);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
